// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first.
// Operands and result move over valid/ready handshakes.
`timescale 1ns/1ps

module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last;

  assign last = (cnt == LAST);

  full_adder1 u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand load, then one bit per clock into sum_sh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry_q <= fa_carry;
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = carry_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomized checks for bit_serial_adder.
// Instances at WIDTH 8, 2 and 32.
`timescale 1ns/1ps

module tb_bit_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  logic       iv2, ir2, ov2, or2;
  logic [1:0] a2, b2, sum2;
  logic       cin2, cout2, busy2;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, sum32;
  logic        cin32, cout32, busy32;

  int n_chk;
  int n_fail;

  logic [8:0] exp_q[$];

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  bit_serial_adder #(.WIDTH(2)) u2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .out_valid (ov2),
    .out_ready (or2),
    .sum       (sum2),
    .cout      (cout2),
    .busy      (busy2)
  );

  bit_serial_adder #(.WIDTH(32)) u32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv32),
    .in_ready  (ir32),
    .a         (a32),
    .b         (b32),
    .cin       (cin32),
    .out_valid (ov32),
    .out_ready (or32),
    .sum       (sum32),
    .cout      (cout32),
    .busy      (busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; stop once out_valid is seen.
  task automatic op8(
    input  logic [7:0] av,
    input  logic [7:0] bv,
    input  logic       cv,
    output logic [7:0] s,
    output logic       co,
    output int         lat,
    output bit         bad
  );
    int w;
    w = 0;
    bad = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready || !busy) bad = 1;
      tick();
      lat++;
    end
    s = sum;
    co = cout;
  endtask

  task automatic release8();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({in_ready, out_valid, busy, cout, sum} !== 12'h800) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b ov=%b busy=%b co=%b sum=%h want 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b ov=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s;
    logic co;
    int lat;
    bit bad;
    op8(8'h5A, 8'h33, 1'b0, s, co, lat, bad);
    n_chk++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    n_chk++;
    if ({co, s} !== 9'h08D) begin
      n_fail++;
      $display("FAIL basic_sum: got %b/%h want 0/8d", co, s);
    end
    n_chk++;
    if (bad !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_flags: bad=%b busy=%b rdy=%b want 0 1 0",
               bad, busy, in_ready);
    end
    release8();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_corners();
    logic [7:0] av[3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] bv[3] = '{8'h01, 8'hFF, 8'h00};
    logic       cv[3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] ev[3] = '{9'h100, 9'h1FF, 9'h001};
    logic [7:0] s;
    logic co;
    int lat;
    bit bad;
    for (int i = 0; i < 3; i++) begin
      op8(av[i], bv[i], cv[i], s, co, lat, bad);
      n_chk++;
      if ({co, s} !== ev[i] || lat !== 8) begin
        n_fail++;
        $display("FAIL corner%0d: got %h lat %0d want %h lat 8",
                 i, {co, s}, lat, ev[i]);
      end
      release8();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s;
    logic co;
    int lat;
    bit bad;
    op8(8'h81, 8'h82, 1'b1, s, co, lat, bad);
    n_chk++;
    if ({co, s} !== 9'h104) begin
      n_fail++;
      $display("FAIL bp_sum: got %h want 104", {co, s});
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a = 8'h11;
      b = 8'h22;
      cin = 1'b0;
      tick();
      in_valid = 1'b0;
      n_chk++;
      if ({out_valid, cout, sum} !== 10'h304) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got ov=%b %b/%h want 1 1/04",
                 i, out_valid, cout, sum);
      end
    end
    release8();
    n_chk++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b busy=%b want 1 0",
               in_ready, busy);
    end
    op8(8'h12, 8'h34, 1'b0, s, co, lat, bad);
    n_chk++;
    if ({co, s} !== 9'h046 || lat !== 8) begin
      n_fail++;
      $display("FAIL bp_next: got %h lat %0d want 046 lat 8",
               {co, s}, lat);
    end
    release8();
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s;
    logic co;
    int lat;
    bit bad;
    bit saw_ov;
    in_valid = 1'b1;
    a = 8'hAB;
    b = 8'hCD;
    cin = 1'b1;
    tick();
    in_valid = 1'b0;
    saw_ov = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) saw_ov = 1;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (saw_ov || {in_ready, out_valid, busy, cout, sum} !== 12'h800) begin
      n_fail++;
      $display("FAIL mid_reset: ov_seen=%b rdy=%b ov=%b busy=%b %b/%h want 0 1 0 0 0/00",
               saw_ov, in_ready, out_valid, busy, cout, sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    op8(8'h10, 8'h0F, 1'b0, s, co, lat, bad);
    n_chk++;
    if ({co, s} !== 9'h01F || lat !== 8) begin
      n_fail++;
      $display("FAIL mid_reset_after: got %h lat %0d want 01f lat 8",
               {co, s}, lat);
    end
    release8();
  endtask

  task automatic test_widths();
    int lat;
    iv2 = 1'b1;
    a2 = 2'b11;
    b2 = 2'b01;
    cin2 = 1'b0;
    tick();
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 10) begin
      tick();
      lat++;
    end
    n_chk++;
    if ({cout2, sum2} !== 3'b100 || lat !== 2) begin
      n_fail++;
      $display("FAIL width2: got %b/%b lat %0d want 1/00 lat 2",
               cout2, sum2, lat);
    end
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
    iv32 = 1'b1;
    a32 = 32'hFFFF_FFFF;
    b32 = 32'h1;
    cin32 = 1'b0;
    tick();
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 60) begin
      tick();
      lat++;
    end
    n_chk++;
    if ({cout32, sum32} !== 33'h1_0000_0000 || lat !== 32) begin
      n_fail++;
      $display("FAIL width32: got %b/%h lat %0d want 1/00000000 lat 32",
               cout32, sum32, lat);
    end
    or32 = 1'b1;
    tick();
    or32 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int got;
    int guard;
    exp_q.delete();
    got = 0;
    fork
      begin
        logic [7:0] av, bv;
        logic cv;
        bit hs;
        int w;
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          av = 8'($urandom);
          bv = 8'($urandom);
          cv = 1'($urandom);
          in_valid = 1'b1;
          a = av;
          b = bv;
          cin = cv;
          hs = 0;
          w = 0;
          while (!hs && w < 100) begin
            hs = in_ready;
            tick();
            w++;
          end
          in_valid = 1'b0;
          if (!hs) begin
            n_chk++;
            n_fail++;
            $display("FAIL b2b_accept: op %0d not accepted", i);
            break;
          end
          exp_q.push_back({1'b0, av} + {1'b0, bv} + {8'h00, cv});
        end
      end
      begin
        logic ov, rd;
        logic [8:0] res, e;
        guard = 0;
        while (got < 1000 && guard < 40000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          ov = out_valid;
          rd = out_ready;
          res = {cout, sum};
          tick();
          guard++;
          if (ov && rd) begin
            n_chk++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL b2b_extra: result %h with none pending", res);
            end else begin
              e = exp_q.pop_front();
              if (res !== e) begin
                n_fail++;
                $display("FAIL b2b_result%0d: got %h want %h", got, res, e);
              end
            end
            got++;
          end
        end
        out_ready = 1'b0;
      end
    join
    n_chk++;
    if (got !== 1000 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, %0d pending, want 1000, 0",
               got, exp_q.size());
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    iv2 = 1'b0;
    or2 = 1'b0;
    a2 = '0;
    b2 = '0;
    cin2 = 1'b0;
    iv32 = 1'b0;
    or32 = 1'b0;
    a32 = '0;
    b32 = '0;
    cin32 = 1'b0;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_widths();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
